ex_muldiv_unit: RTL

Iterative RV64M multiply/divide execute unit that consumes the operand, destination and function fields delivered by the ID/EX pipeline register and returns a result toward the EX/MEM register. It sits beside the single-cycle ALU in the EX stage. A valid/ready handshake on both sides lets the hazard logic stall the front of the pipeline while an operation is in flight. Squashed instructions are discarded by a flush input.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/div_step.sv | 21 ++
 rtl/ex_muldiv_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int CNT_WIDTH  = 7;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor, so the shifted value is below 2*divisor and fits WIDTH+1 bits
  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide execute unit: shift-add multiply, restoring divide,
// sign handled as magnitudes plus a final conditional negate.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              func3,
  input  logic                    is_word,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  input  logic [REG_ID_WIDTH-1:0] dest_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [REG_ID_WIDTH-1:0] dest_out,
  output logic                    busy
);

  localparam int W = DATA_WIDTH;

  function automatic logic [W-1:0] sext_word(input logic [WORD_WIDTH-1:0] v);
    return {{(W-WORD_WIDTH){v[WORD_WIDTH-1]}}, v};
  endfunction

  muldiv_state_e state_reg, state_next;
  muldiv_op_e    op_reg;
  logic          word_reg, neg_reg;
  logic [W-1:0]  mcand_reg, shift_reg, result_reg;
  logic [2*W-1:0] acc_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [REG_ID_WIDTH-1:0] dest_reg;

  logic accept;
  assign accept = in_valid && in_ready && !flush;

  // Accept-time operand decode
  muldiv_op_e op_in;
  logic sign_a, sign_b, a_neg, b_neg, res_neg, div_zero, overflow, special;
  logic [W-1:0] a_ext, b_ext, a_mag, b_mag, min_val, dividend_val, special_val;

  always_comb begin
    op_in = muldiv_op_e'(func3);
    if (is_word && (func3 == 3'd1 || func3 == 3'd2 || func3 == 3'd3)) op_in = OP_MUL;
    sign_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    sign_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_ext = op_a;
    b_ext = op_b;
    if (is_word) begin
      a_ext = sign_a ? sext_word(op_a[WORD_WIDTH-1:0]) : {{(W-WORD_WIDTH){1'b0}}, op_a[WORD_WIDTH-1:0]};
      b_ext = sign_b ? sext_word(op_b[WORD_WIDTH-1:0]) : {{(W-WORD_WIDTH){1'b0}}, op_b[WORD_WIDTH-1:0]};
    end
    a_neg = sign_a && a_ext[W-1];
    b_neg = sign_b && b_ext[W-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    case (op_in)
      OP_MULH, OP_DIV:   res_neg = a_neg ^ b_neg;
      OP_MULHSU, OP_REM: res_neg = a_neg;
      default:           res_neg = 1'b0;
    endcase
    min_val = is_word ? sext_word({1'b1, {(WORD_WIDTH-1){1'b0}}}) : {1'b1, {(W-1){1'b0}}};
    div_zero = func3[2] && (b_ext == '0);
    overflow = ((op_in == OP_DIV) || (op_in == OP_REM)) && (a_ext == min_val) && (b_ext == '1);
    special  = div_zero || overflow;
    dividend_val = is_word ? sext_word(op_a[WORD_WIDTH-1:0]) : op_a;
    // func3[1] separates remainder from quotient among the divide encodings
    if (div_zero) special_val = func3[1] ? dividend_val : '1;
    else          special_val = func3[1] ? '0 : dividend_val;
  end

  // Iteration datapath
  logic [W-1:0] rem_next;
  logic         q_bit;
  logic [W:0]   mul_sum;
  logic [CNT_WIDTH-1:0] n_last;

  div_step #(.WIDTH(W)) u_div_step (
    .rem_in       (acc_reg[2*W-1:W]),
    .dividend_bit (shift_reg[W-1]),
    .divisor      (mcand_reg),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  assign mul_sum = {1'b0, acc_reg[2*W-1:W]} + (shift_reg[0] ? {1'b0, mcand_reg} : '0);
  assign n_last  = word_reg ? CNT_WIDTH'(WORD_WIDTH-1) : CNT_WIDTH'(W-1);

  // Final result selection, negate and word sign-extension
  logic [2*W-1:0] prod;
  logic [W-1:0]   sel, fixed;

  always_comb begin
    // MULH sign must be applied to the full product, not just its high half
    prod = neg_reg ? -acc_reg : acc_reg;
    case (op_reg)
      OP_MUL:                       sel = word_reg ? {{(W-WORD_WIDTH){1'b0}}, prod[W-1:W-WORD_WIDTH]} : prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: sel = prod[2*W-1:W];
      OP_DIV, OP_DIVU:              sel = neg_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
      default:                      sel = neg_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
    endcase
    fixed = word_reg ? sext_word(sel[WORD_WIDTH-1:0]) : sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg <= OP_MUL; word_reg <= 1'b0; neg_reg <= 1'b0;
      mcand_reg <= '0; shift_reg <= '0; acc_reg <= '0; cnt_reg <= '0;
      result_reg <= '0; dest_reg <= '0;
    end else if (accept) begin
      op_reg    <= op_in;
      word_reg  <= is_word;
      neg_reg   <= res_neg;
      dest_reg  <= dest_in;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      mcand_reg <= func3[2] ? b_mag : a_mag;
      // Word dividends sit in the upper half so MSB-first shifting needs only 32 steps
      shift_reg <= func3[2] ? (is_word ? (a_mag << WORD_WIDTH) : a_mag) : b_mag;
      if (special) result_reg <= special_val;
    end else if (!flush && state_reg == S_CALC) begin
      if (op_reg[2]) begin
        acc_reg   <= {rem_next, acc_reg[W-2:0], q_bit};
        shift_reg <= shift_reg << 1;
      end else begin
        acc_reg   <= {mul_sum, acc_reg[W-1:1]};
        shift_reg <= shift_reg >> 1;
      end
      if (cnt_reg != n_last + CNT_WIDTH'(1)) cnt_reg <= cnt_reg + CNT_WIDTH'(1);
    end else if (!flush && state_reg == S_FIXUP) begin
      result_reg <= fixed;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = special ? S_DONE : S_CALC;
      S_CALC:  if (cnt_reg == n_last) state_next = S_FIXUP;
      S_FIXUP: state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_comb begin
    in_ready  = (state_reg == S_IDLE);
    out_valid = (state_reg == S_DONE);
    busy      = (state_reg != S_IDLE);
  end

  assign result   = result_reg;
  assign dest_out = dest_reg;

endmodule
